// File: rtl/route_req_queue.sv
// Route request queue: edge-detects host route requests and buffers them in a
// small circular FIFO that feeds the input-0 arbiter.
module route_req_queue #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     router_start_req,
    input  logic [ADDR_W-1:0]        router_scr_addr,
    input  logic [ADDR_W-1:0]        router_dst_addr,
    output logic                     arb_req_valid,
    input  logic                     arb_req_ready,
    output logic [ADDR_W-1:0]        arb_scr_addr,
    output logic [ADDR_W-1:0]        arb_dst_addr,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     err_self,
    output logic [7:0]               drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                    req_q;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [2*ADDR_W-1:0]     mem [DEPTH];
    logic [2*ADDR_W-1:0]     head;

    logic detect;
    logic self_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A level held over several cycles is a single request.
    assign detect   = router_start_req & ~req_q;
    assign self_req = detect & (router_scr_addr == router_dst_addr);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = (count != '0) & arb_req_ready;
    assign push     = detect & ~self_req & (~full | pop);
    assign drop     = detect & ~self_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_self <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            req_q    <= router_start_req;
            err_self <= self_req;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {router_scr_addr, router_dst_addr};
        end
    end

    assign head          = mem[rd_ptr];
    assign arb_req_valid = (count != '0);
    assign arb_scr_addr  = arb_req_valid ? head[2*ADDR_W-1:ADDR_W] : '0;
    assign arb_dst_addr  = arb_req_valid ? head[ADDR_W-1:0] : '0;
    assign q_count       = count;
    assign q_full        = full;

endmodule
